// File: rtl/spi_master_ctrl.sv
// SPI master for the 10-bit command/address/data frame used by the SPI slave + RAM subsystem.
// Sends one frame MSB-first per host request and captures the returned byte on read-data frames.
module spi_master_ctrl #(
  parameter int unsigned RD_WAIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [9:0] frame,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_CMD,
    S_SHIFT,
    S_WAIT,
    S_CAPTURE,
    S_END
  } state_e;

  localparam logic [3:0] WAIT_LOAD = 4'(RD_WAIT - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [9:0] shadow_q, shadow_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       ss_n_q, ss_n_d;
  logic       mosi_q, mosi_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       rd_valid_q, rd_valid_d;
  logic       is_rd;

  assign is_rd = (shadow_q[9:8] == 2'b11);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    shift_d   = shift_q;
    rd_data_d = rd_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_SELECT;
          shadow_d = frame;
        end
      end
      S_SELECT: state_d = S_CMD;
      S_CMD: begin
        state_d = S_SHIFT;
        cnt_d   = 4'd9;
      end
      S_SHIFT: begin
        if (cnt_q == 4'd0) begin
          if (is_rd) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = S_END;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_CAPTURE;
          cnt_d   = 4'd7;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_CAPTURE: begin
        shift_d[cnt_q[2:0]] = MISO;
        if (cnt_q == 4'd0) state_d = S_END;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_END:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so their registers line up with the state they describe.
    ss_n_d     = (state_d == S_IDLE) || (state_d == S_END);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_END);
    rd_valid_d = done_d && is_rd;
    if (rd_valid_d) rd_data_d = shift_d;

    unique case (state_d)
      S_SELECT, S_CMD: mosi_d = shadow_d[9];
      S_SHIFT:         mosi_d = shadow_d[cnt_d];
      default:         mosi_d = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      shadow_q   <= 10'd0;
      shift_q    <= 8'd0;
      rd_data_q  <= 8'd0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      shift_q    <= shift_d;
      rd_data_q  <= rd_data_d;
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign SS_n     = ss_n_q;
  assign MOSI     = mosi_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Single-clock SPI master that drives the 10-bit command/address/data frame consumed by the team's SPI slave + single-port RAM subsystem.
- A host issues one frame at a time. The block asserts SS_n, serializes the frame MSB-first on MOSI and releases SS_n.
- For read-data frames it also captures the 8-bit byte returned on MISO.
- MOSI/MISO are sampled and updated on clk edges; there is no separate SCLK.

Parameters:
- RD_WAIT, 4: cycles between the last MOSI bit and the first MISO capture cycle on read-data frames. Must match the slave+RAM turnaround; legal range 1..15.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- start  input  1  host request, accepted only when busy=0
- frame  input  10  frame to send; [9:8] command (00 wr addr, 01 wr data, 10 rd addr, 11 rd data), [7:0] payload
- busy  output  1  high from cycle after acceptance until transaction end
- done  output  1  one-cycle pulse at end of every transaction
- rd_data  output  8  byte captured from MISO; holds until next read-data frame
- rd_valid  output  1  one-cycle pulse, coincident with done, read-data frames only
- SS_n  output  1  slave select, active low
- MOSI  output  1  serial data to slave
- MISO  input  1  serial data from slave

Behaviour:
- Reset: synchronous, active-low, clock clk. SS_n=1, MOSI=0, busy=0, done=0, rd_valid=0, rd_data=0, state IDLE. Reset asserted mid-frame aborts it: SS_n=1 on the next edge, no done/rd_valid pulse.
- All outputs are registered.
- States: IDLE, SELECT, CMD, SHIFT, WAIT, CAPTURE, END.
- Cycle k = cycle with start=1 and busy=0. frame is latched into a 10-bit shadow register. start while busy=1 is ignored and has no side effects.
- IDLE -> SELECT at k.
  - k+1 (SELECT): SS_n=0, MOSI=frame[9], busy=1.
- SELECT -> CMD.
  - k+2 (CMD): MOSI=frame[9]; this is the command-select bit the slave samples.
- CMD -> SHIFT, 4-bit down-counter loaded with 9.
  - k+3..k+12 (SHIFT): MOSI=frame[cnt], cnt 9 down to 0, one bit per cycle.
- After SHIFT:
  - If frame[9:8]!=2'b11: go to END at k+13.
  - Else: go to WAIT, MOSI=0, SS_n stays 0, for RD_WAIT cycles (k+13..k+12+RD_WAIT).
- CAPTURE: 8 cycles, counter 7 down to 0. At each rising edge ending a CAPTURE cycle, MISO is stored into shift[cnt] (MSB first). SS_n stays 0, MOSI=0. Then go to END.
- END: one cycle. SS_n=1, MOSI=0, done=1. For read-data frames, also rd_valid=1 and rd_data=captured byte.
  - busy=0 on the cycle after END, and the state returns to IDLE.
  - END guarantees at least one SS_n-high cycle between frames, which the slave needs to return to its idle state.
- Transaction lengths:
  - Non-read frame: SS_n low for exactly 12 cycles (k+1..k+12); done at k+13.
  - Read-data frame: SS_n low for 12+RD_WAIT+8 cycles; done at k+21+RD_WAIT.
- Back-to-back: start held high continuously is accepted on the first cycle with busy=0. Minimum frame spacing is therefore 14 cycles for non-read frames.
- The host may change the frame input after acceptance without effect.
- The MOSI bit order is fixed; no CPOL/CPHA options.

Test Plan:
- Reset then idle 5 cycles -> SS_n=1, MOSI=0, busy=0, done=0, rd_valid=0, rd_data=0x00.
- start with frame=10'b00_1010_0101 -> SS_n low k+1..k+12; MOSI: 0,0 on k+1..k+2, then 0,0,1,0,1,0,0,1,0,1 on k+3..k+12; done at k+13; rd_valid stays 0.
- Write-addr 0x3C, write-data 0xA7, read-addr 0x3C, read-data, with the slave+RAM model attached and RD_WAIT=4 -> read-data frame rd_data=0xA7, rd_valid and done both pulse at k+25.
- start pulsed again at k+5 of an active frame with a different frame value -> ignored; MOSI sequence and timing are unchanged.
- rst_n low for 1 cycle at k+8 of a read-data frame -> SS_n=1, busy=0 next edge; no done; next start runs a clean full frame.
- start held high with two queued frames -> second SS_n falling edge exactly 14 cycles after the first, with at least 1 SS_n-high cycle between frames.
